stopwatch_time_laps: RTL and testbench

- Datapath stage directly downstream of the stopwatch control FSM.
- Consumes the FSM's running and display_select outputs plus the qualified lap pulse.
- Keeps the BCD elapsed time (MM:SS.cc), captures two lap snapshots and drives the registered time word selected for the 7-segment display driver.

---
 rtl/stopwatch_time_laps.sv | 124 ++++++++++++
 tb/tb_stopwatch_time_laps.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_time_laps.sv
// Stopwatch datapath: BCD elapsed time MM:SS.cc, two lap slots,
// and the registered time word chosen for the 7-segment driver.
module stopwatch_time_laps #(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned TICK_HZ     = 100
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        running,
    input  logic        lap,
    input  logic        clear,
    input  logic [1:0]  display_select,
    output logic [23:0] time_bcd,
    output logic [23:0] disp_bcd,
    output logic [1:0]  lap_valid,
    output logic        tick
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   time_q, time_d;
    logic [23:0]   lap1_q, lap1_d;
    logic [23:0]   lap2_q, lap2_d;
    logic          ptr_q, ptr_d;
    logic [1:0]    valid_q, valid_d;
    logic [23:0]   disp_q, disp_d;
    logic          tick_w;

    // Ripple-carry BCD increment; digit limits from cs_u up are 9,9,9,5,9,5.
    // Using >= keeps any out-of-range digit from ever escaping.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        c;
        logic [3:0]  lim;
        r = t;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (c) begin
                if (r[i*4 +: 4] >= lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick_w = running && (presc_q == TC);

    // Next-state for prescaler, time, lap slots; clear only while stopped
    always_comb begin
        presc_d = presc_q;
        time_d  = time_q;
        lap1_d  = lap1_q;
        lap2_d  = lap2_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        if (!running && clear) begin
            presc_d = '0;
            time_d  = '0;
            lap1_d  = '0;
            lap2_d  = '0;
            ptr_d   = 1'b0;
            valid_d = 2'b00;
        end else if (running) begin
            presc_d = tick_w ? '0 : presc_q + PW'(1);
            if (tick_w) begin
                time_d = bcd_inc(time_q);
            end
            if (lap) begin
                if (ptr_q) begin
                    lap2_d = time_q;
                end else begin
                    lap1_d = time_q;
                end
                valid_d[ptr_q] = 1'b1;
                ptr_d = ~ptr_q;
            end
        end
    end

    // Display word select; an empty slot reads as zero
    always_comb begin
        disp_d = time_q;
        case (display_select)
            2'b01:   disp_d = valid_q[0] ? lap1_q : '0;
            2'b10:   disp_d = valid_q[1] ? lap2_q : '0;
            default: disp_d = time_q;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q <= '0;
            time_q  <= '0;
            lap1_q  <= '0;
            lap2_q  <= '0;
            ptr_q   <= 1'b0;
            valid_q <= 2'b00;
            disp_q  <= '0;
        end else begin
            presc_q <= presc_d;
            time_q  <= time_d;
            lap1_q  <= lap1_d;
            lap2_q  <= lap2_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            disp_q  <= disp_d;
        end
    end

    assign time_bcd  = time_q;
    assign disp_bcd  = disp_q;
    assign lap_valid = valid_q;
    assign tick      = tick_w;

endmodule

// File: tb/tb_stopwatch_time_laps.sv
// Directed table-driven bench for stopwatch_time_laps with TICK_DIV=10.
// Each record holds inputs for n clocks, then expected outputs.
module tb_stopwatch_time_laps;

    logic        clk;
    logic        rstn;
    logic        running;
    logic        lap;
    logic        clear;
    logic [1:0]  display_select;
    logic [23:0] time_bcd;
    logic [23:0] disp_bcd;
    logic [1:0]  lap_valid;
    logic        tick;

    int n_vec;
    int n_err;

    stopwatch_time_laps #(
        .CLK_FREQ_HZ(1000),
        .TICK_HZ    (100)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .running       (running),
        .lap           (lap),
        .clear         (clear),
        .display_select(display_select),
        .time_bcd      (time_bcd),
        .disp_bcd      (disp_bcd),
        .lap_valid     (lap_valid),
        .tick          (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        lp;
        logic        cl;
        logic [1:0]  sel;
        int          n;
        logic [23:0] t;
        logic [23:0] d;
        logic [1:0]  v;
        logic        tk;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rn, input logic lp,
                                input logic cl, input logic [1:0] sel,
                                input int n, input logic [23:0] t,
                                input logic [23:0] d, input logic [1:0] v,
                                input logic tk);
        vec_t e;
        e.rn = rn; e.lp = lp; e.cl = cl; e.sel = sel; e.n = n;
        e.t = t; e.d = d; e.v = v; e.tk = tk;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [23:0] act,
                       input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        running = 1'b0;
        lap = 1'b0;
        clear = 1'b0;
        display_select = 2'b00;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("rst time", time_bcd, 24'h0);
        chk("rst disp", disp_bcd, 24'h0);
        chk("rst valid", {22'h0, lap_valid}, 24'h0);
        chk("rst tick", {23'h0, tick}, 24'h0);
        cycles(2);
        rstn = 1'b1;

        // rn lp cl sel n  time  disp  valid tick
        add(1, 0, 0, 2'b00, 100,   24'h000010, 24'h000009, 2'b00, 0);
        add(1, 0, 0, 2'b00, 1130,  24'h000123, 24'h000122, 2'b00, 0);
        add(1, 1, 0, 2'b00, 1,     24'h000123, 24'h000123, 2'b01, 0);
        add(1, 0, 0, 2'b00, 1269,  24'h000250, 24'h000249, 2'b01, 0);
        add(1, 1, 0, 2'b00, 1,     24'h000250, 24'h000250, 2'b11, 0);
        add(1, 0, 0, 2'b01, 1,     24'h000250, 24'h000123, 2'b11, 0);
        add(1, 0, 0, 2'b10, 1,     24'h000250, 24'h000250, 2'b11, 0);
        add(1, 0, 0, 2'b10, 497,   24'h000300, 24'h000250, 2'b11, 0);
        add(1, 1, 0, 2'b01, 1,     24'h000300, 24'h000123, 2'b11, 0);
        add(1, 0, 0, 2'b01, 1,     24'h000300, 24'h000300, 2'b11, 0);
        add(1, 0, 0, 2'b00, 7,     24'h000300, 24'h000300, 2'b11, 1);
        add(1, 1, 0, 2'b10, 1,     24'h000301, 24'h000250, 2'b11, 0);
        add(1, 0, 0, 2'b10, 1,     24'h000301, 24'h000300, 2'b11, 0);
        add(1, 0, 0, 2'b00, 6,     24'h000301, 24'h000301, 2'b11, 0);
        add(0, 0, 0, 2'b00, 20,    24'h000301, 24'h000301, 2'b11, 0);
        add(1, 0, 0, 2'b00, 1,     24'h000301, 24'h000301, 2'b11, 0);
        add(1, 0, 0, 2'b00, 1,     24'h000301, 24'h000301, 2'b11, 1);
        add(1, 0, 0, 2'b00, 1,     24'h000302, 24'h000301, 2'b11, 0);
        add(1, 0, 1, 2'b00, 1,     24'h000302, 24'h000302, 2'b11, 0);
        add(0, 0, 0, 2'b00, 1,     24'h000302, 24'h000302, 2'b11, 0);
        add(0, 0, 1, 2'b00, 1,     24'h000000, 24'h000302, 2'b00, 0);
        add(0, 0, 0, 2'b01, 1,     24'h000000, 24'h000000, 2'b00, 0);
        add(0, 1, 1, 2'b00, 1,     24'h000000, 24'h000000, 2'b00, 0);
        add(0, 1, 0, 2'b00, 1,     24'h000000, 24'h000000, 2'b00, 0);
        add(1, 0, 0, 2'b00, 59990, 24'h005999, 24'h005998, 2'b00, 0);
        add(1, 0, 0, 2'b00, 9,     24'h005999, 24'h005999, 2'b00, 1);
        add(1, 0, 0, 2'b00, 1,     24'h010000, 24'h005999, 2'b00, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            running = tbl[i].rn;
            lap = tbl[i].lp;
            clear = tbl[i].cl;
            display_select = tbl[i].sel;
            cycles(tbl[i].n);
            chk($sformatf("v%0d time", i), time_bcd, tbl[i].t);
            chk($sformatf("v%0d disp", i), disp_bcd, tbl[i].d);
            chk($sformatf("v%0d valid", i), {22'h0, lap_valid},
                {22'h0, tbl[i].v});
            chk($sformatf("v%0d tick", i), {23'h0, tick},
                {23'h0, tbl[i].tk});
        end

        // Fresh start, one lap at 00:00.00, run to 00:05.42
        running = 1'b0;
        lap = 1'b0;
        clear = 1'b0;
        display_select = 2'b01;
        rstn = 1'b0;
        cycles(1);
        rstn = 1'b1;
        running = 1'b1;
        lap = 1'b1;
        cycles(1);
        lap = 1'b0;
        cycles(5419);
        chk("pre-rst time", time_bcd, 24'h000542);
        chk("pre-rst valid", {22'h0, lap_valid}, 24'h1);

        // Asynchronous reset between clock edges
        #3 rstn = 1'b0;
        #1;
        chk("arst time", time_bcd, 24'h0);
        chk("arst disp", disp_bcd, 24'h0);
        chk("arst valid", {22'h0, lap_valid}, 24'h0);
        chk("arst tick", {23'h0, tick}, 24'h0);
        running = 1'b0;
        cycles(1);
        rstn = 1'b1;
        display_select = 2'b00;
        cycles(3);
        chk("idle time", time_bcd, 24'h0);
        running = 1'b1;
        cycles(9);
        chk("resume tick", {23'h0, tick}, 24'h1);
        chk("resume time0", time_bcd, 24'h0);
        cycles(1);
        chk("resume time1", time_bcd, 24'h000001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
